// File: rtl/mem_copy_pkg.sv
// mem_copy_pkg: shared types and constants for the block-copy RAM initiator.
package mem_copy_pkg;

    // Addresses advance by one 32-bit word per transfer.
    localparam int BYTES_PER_WORD = 4;

    // Copy engine states.
    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        DONE
    } state_t;

    // Request kinds any initiator may place on the ALU RAM port.
    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_READ,
        REQ_WRITE
    } req_t;

endpackage

// File: rtl/mem_copy_dma_if.sv
// mem_copy_dma_if: ALU RAM request port (initiator = master, memory responder = slave).
interface mem_copy_dma_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] ramAddress;
    logic [DATA_W-1:0] ramOut;
    logic              readReq;
    logic              writeReq;
    logic [DATA_W-1:0] ramValue;

    modport master (
        output ramAddress,
        output ramOut,
        output readReq,
        output writeReq,
        input  ramValue
    );

    modport slave (
        input  ramAddress,
        input  ramOut,
        input  readReq,
        input  writeReq,
        output ramValue
    );
endinterface

// File: rtl/mem_copy_dma.sv
// mem_copy_dma: copies a block of 32-bit words between RAM byte addresses over the ALU RAM port.
// Optional MEM_COPY_DMA_CHECKSUM_EN adds a running 32-bit sum of the copied words.
module mem_copy_dma
    import mem_copy_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] srcAddr,
    input  logic [ADDR_W-1:0] dstAddr,
    input  logic [CNT_W-1:0]  wordCount,
    output logic              busy,
    output logic              done,
`ifdef MEM_COPY_DMA_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    mem_copy_dma_if.master    ram
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              accept;
    req_t              req_d;

    // Next state, pointer/count updates, and registered bus outputs derived from the next state.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                accept  = 1'b1;
                src_d   = srcAddr;
                dst_d   = dstAddr;
                cnt_d   = wordCount;
                state_d = (wordCount == '0) ? DONE : READ;
            end
            READ:  state_d = WAIT;
            WAIT: begin
                data_d  = ram.ramValue;
                state_d = WRITE;
            end
            WRITE: begin
                src_d   = src_q + ADDR_W'(BYTES_PER_WORD);
                dst_d   = dst_q + ADDR_W'(BYTES_PER_WORD);
                cnt_d   = cnt_q - CNT_W'(1);
                state_d = (cnt_q == CNT_W'(1)) ? DONE : READ;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        req_d   = (state_d == READ) ? REQ_READ : (state_d == WRITE) ? REQ_WRITE : REQ_NONE;
        rd_d    = (req_d == REQ_READ);
        wr_d    = (req_d == REQ_WRITE);
        addr_d  = rd_d ? src_d : wr_d ? dst_d : addr_q;
        wdata_d = wr_d ? data_d : wdata_q;
        busy_d  = (state_d == READ) || (state_d == WAIT) || (state_d == WRITE);
        done_d  = (state_d == DONE);
    end

    // State, datapath and output registers; reset abandons any copy in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ram.ramAddress = addr_q;
    assign ram.ramOut     = wdata_q;
    assign ram.readReq    = rd_q;
    assign ram.writeReq   = wr_q;
    assign busy           = busy_q;
    assign done           = done_q;

`ifdef MEM_COPY_DMA_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;

    // Sum restarts on each accepted copy and accumulates every word as it is written.
    always_comb begin
        sum_d = accept ? '0 : (state_q == WRITE) ? sum_q + data_q : sum_q;
    end

    // Checksum accumulator register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sum_q <= '0;
        else        sum_q <= sum_d;
    end

    assign checksum = sum_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule
